// File: rtl/sar_search.sv
// Successive-approximation search: bisects [0, 2^size-1] against an external comparator
// that sees the target on A and the probe value `guess` on B.
module sar_search #(
    parameter int unsigned size = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [size-1:0] guess,
    input  logic            A_greater,
    input  logic            B_greater,
    input  logic            AB_equal,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic            error,
    output logic [size-1:0] result
);

    localparam int unsigned CntW = $clog2(size + 2);

    typedef enum logic [1:0] {StIdle, StProbe, StDone} state_e;

    state_e            state_q, state_d;
    logic [size:0]     low_q, low_d, high_q, high_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              found_q, found_d, error_q, error_d;
    logic [size-1:0]   result_q, result_d;

    logic [size+1:0]   sum;
    logic [size-1:0]   mid;
    logic              flags_onehot, at_min, at_max, limit_hit;

    // Bounds are one bit wider than the operand so guess+1 / guess-1 never wrap.
    assign sum          = {1'b0, low_q} + {1'b0, high_q};
    assign mid          = sum[size:1];
    assign flags_onehot = $onehot({A_greater, B_greater, AB_equal});
    assign at_min       = (mid == '0);
    assign at_max       = (mid == {size{1'b1}});
    assign limit_hit    = (count_q == CntW'(size));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            low_q    <= '0;
            high_q   <= '0;
            count_q  <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            low_q    <= low_d;
            high_q   <= high_d;
            count_q  <= count_d;
            found_q  <= found_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        low_d    = low_q;
        high_d   = high_q;
        count_d  = count_q;
        found_d  = found_q;
        error_d  = error_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StProbe;
                    low_d   = '0;
                    high_d  = {1'b0, {size{1'b1}}};
                    count_d = '0;
                    found_d = 1'b0;
                    error_d = 1'b0;
                end
            end
            StProbe: begin
                if (!flags_onehot) begin
                    state_d = StDone;
                    found_d = 1'b0;
                    error_d = 1'b1;
                end else if (AB_equal) begin
                    state_d  = StDone;
                    result_d = mid;
                    found_d  = 1'b1;
                    error_d  = 1'b0;
                end else if ((A_greater && at_max) || (B_greater && at_min) || limit_hit) begin
                    // Comparator disagrees with the remaining range, or one probe too many.
                    state_d = StDone;
                    found_d = 1'b0;
                    error_d = 1'b1;
                end else begin
                    count_d = count_q + CntW'(1);
                    if (A_greater) begin
                        low_d = {1'b0, mid} + {{size{1'b0}}, 1'b1};
                    end else begin
                        high_d = {1'b0, mid} - {{size{1'b0}}, 1'b1};
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == StProbe);
        done   = (state_q == StDone);
        guess  = busy ? mid : '0;
        found  = found_q;
        error  = error_q;
        result = result_q;
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (size=4) driving a comparator model with optional faulty
// flag behaviours; all expectations are hand-computed bisection sequences.
module tb_sar_search;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] guess;
    logic       A_greater, B_greater, AB_equal;
    logic       busy, done, found, error;
    logic [3:0] result;

    logic [3:0] target;
    int         mode;
    int         n_checks;
    int         n_errors;
    int         seen[$];
    int         exp_seq[$];

    sar_search #(.size(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .guess    (guess),
        .A_greater(A_greater),
        .B_greater(B_greater),
        .AB_equal (AB_equal),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .error    (error),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0 ideal; 1 all low; 2 A and B high; 3 always B; 4 always A;
    // 5 inconsistent (A at 7/9 else B) to exhaust the probe budget.
    always_comb begin
        A_greater = 1'b0;
        B_greater = 1'b0;
        AB_equal  = 1'b0;
        case (mode)
            0: begin
                A_greater = target > guess;
                B_greater = target < guess;
                AB_equal  = target == guess;
            end
            2: begin
                A_greater = 1'b1;
                B_greater = 1'b1;
            end
            3: B_greater = 1'b1;
            4: A_greater = 1'b1;
            5: begin
                A_greater = (guess == 4'd7) || (guess == 4'd9);
                B_greater = !A_greater;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulses (or holds) start, logs every PROBE guess, returns at the negedge showing done.
    task automatic run_search(input logic [3:0] tgt, input int md, input bit hold);
        target = tgt;
        mode   = md;
        seen.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) seen.push_back(int'(guess));
            @(negedge clk);
        end
        check("done_reached", int'(done), 1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, seen.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < seen.size(); i++) begin
            check($sformatf("%s_g%0d", tag, i), seen[i], exp_seq[i]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        target   = 4'd0;
        mode     = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_guess", int'(guess), 0);
        check("rst_result", int'(result), 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_stays", int'(busy), 0);

        // Target 7: hit on the first probe
        run_search(4'd7, 0, 1'b0);
        exp_seq = '{7};
        check_seq("t7");
        check("t7_found", int'(found), 1);
        check("t7_error", int'(error), 0);
        check("t7_result", int'(result), 7);
        @(negedge clk);
        check("t7_done_pulse", int'(done), 0);
        check("t7_found_held", int'(found), 1);

        run_search(4'd15, 0, 1'b0);
        exp_seq = '{7, 11, 13, 14, 15};
        check_seq("t15");
        check("t15_found", int'(found), 1);
        check("t15_result", int'(result), 15);

        run_search(4'd0, 0, 1'b0);
        exp_seq = '{7, 3, 1, 0};
        check_seq("t0");
        check("t0_found", int'(found), 1);
        check("t0_error", int'(error), 0);
        check("t0_result", int'(result), 0);

        // Illegal flag patterns
        run_search(4'd5, 1, 1'b0);
        exp_seq = '{7};
        check_seq("nof");
        check("nof_error", int'(error), 1);
        check("nof_found", int'(found), 0);
        run_search(4'd5, 2, 1'b0);
        exp_seq = '{7};
        check_seq("ab");
        check("ab_error", int'(error), 1);
        check("ab_found", int'(found), 0);

        // Range boundaries and probe budget
        run_search(4'd0, 3, 1'b0);
        exp_seq = '{7, 3, 1, 0};
        check_seq("bmin");
        check("bmin_error", int'(error), 1);
        run_search(4'd0, 4, 1'b0);
        exp_seq = '{7, 11, 13, 14, 15};
        check_seq("amax");
        check("amax_error", int'(error), 1);
        run_search(4'd0, 5, 1'b0);
        exp_seq = '{7, 11, 9, 10, 9};
        check_seq("limit");
        check("limit_error", int'(error), 1);
        check("limit_found", int'(found), 0);

        // Reset on the second PROBE cycle
        target = 4'd12;
        mode   = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rp_g0", int'(guess), 7);
        @(negedge clk);
        check("rp_g1", int'(guess), 11);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rp_busy", int'(busy), 0);
        check("rp_done", int'(done), 0);
        check("rp_error", int'(error), 0);
        check("rp_guess", int'(guess), 0);
        repeat (3) begin
            @(negedge clk);
            check("rp_no_done", int'(done), 0);
        end
        run_search(4'd12, 0, 1'b0);
        exp_seq = '{7, 11, 13, 12};
        check_seq("t12");
        check("t12_result", int'(result), 12);

        // start held high: ignored while busy, restarts right after the done pulse
        run_search(4'd15, 0, 1'b1);
        exp_seq = '{7, 11, 13, 14, 15};
        check_seq("hold");
        @(negedge clk);
        check("hold_idle_busy", int'(busy), 0);
        check("hold_idle_found", int'(found), 1);
        @(negedge clk);
        check("hold_restart_busy", int'(busy), 1);
        check("hold_restart_guess", int'(guess), 7);
        check("hold_found_clear", int'(found), 0);
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
